// File: rtl/print_console_pkg.sv
// Shared definitions for the print console: register offsets, STATUS layout
// and the character that terminates a line.
package print_console_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_COUNT  = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  localparam int STAT_TX_READY  = 0;
  localparam int STAT_BUF_EMPTY = 1;
  localparam int STAT_OVERFLOW  = 2;

  // A STATUS write with this data bit set clears the sticky overflow flag.
  localparam int OVF_CLR_BIT = STAT_OVERFLOW;

  localparam logic [7:0] CHAR_NEWLINE = 8'h0A;

  function automatic logic [31:0] status_word(input logic overflow, input logic buf_empty);
    logic [31:0] w;
    w = '0;
    w[STAT_TX_READY]  = 1'b1;
    w[STAT_BUF_EMPTY] = buf_empty;
    w[STAT_OVERFLOW]  = overflow;
    return w;
  endfunction

endpackage

// File: rtl/print_line_buffer.sv
// Character line buffer: stores bytes, flushes on newline or when full,
// and prints the flushed line to the simulator console when ECHO is set.
module print_line_buffer
  import print_console_pkg::*;
#(
  parameter int BUF_DEPTH = 128,
  parameter bit ECHO      = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_char,
  input  logic       ovf_clr,
  output logic       buf_empty,
  output logic       overflow
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [BUF_DEPTH];
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] level_inc;
  logic          overflow_q, overflow_d;
  logic          full_hit;
  logic          flush;

  always_comb begin
    level_inc  = level_q + LW'(1);
    full_hit   = wr_en && (level_inc == LW'(BUF_DEPTH));
    flush      = wr_en && ((wr_char == CHAR_NEWLINE) || full_hit);
    level_d    = level_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      level_d = flush ? '0 : level_inc;
    end
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (full_hit) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the level alone says which entries are live.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[level_q[AW-1:0]] <= wr_char;
    end
  end

`ifndef SYNTHESIS
  // The flushing character is taken straight from the input, since it is
  // written into storage on this same edge.
  always_ff @(posedge clock) begin
    if (ECHO && reset && flush) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (i < int'(level_q)) begin
          $write("%c", mem_q[i]);
        end
      end
      $write("%c", wr_char);
    end
  end
`endif

  assign buf_empty = (level_q == '0);
  assign overflow  = overflow_q;

endmodule

// File: rtl/print_console.sv
// Memory-mapped console device: single-cycle valid/ready register interface,
// address decode and the running character count.
module print_console
  import print_console_pkg::*;
#(
  parameter int BUF_DEPTH = 128,
  parameter bit ECHO      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        print_valid,
  input  logic        print_instr,
  input  logic [31:0] print_addr,
  input  logic [31:0] print_wdata,
  input  logic [3:0]  print_wstrb,
  output logic [31:0] print_rdata,
  output logic        print_ready
);

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] count_q, count_d;
  logic        is_write;
  reg_sel_e    sel;
  logic        char_wr;
  logic        ovf_clr;
  logic        buf_empty;
  logic        overflow;
  logic        unused_bits;

  assign unused_bits = ^{print_addr[31:4], print_addr[1:0], print_wdata[31:8]};

  always_comb begin
    ready_d  = 1'b0;
    rdata_d  = '0;
    count_d  = count_q;
    char_wr  = 1'b0;
    ovf_clr  = 1'b0;
    is_write = |print_wstrb;
    sel      = reg_sel_e'(print_addr[3:2]);
    // Instruction fetches are acknowledged with zero data and touch nothing.
    if (print_valid) begin
      ready_d = 1'b1;
      if (!print_instr) begin
        if (is_write) begin
          case (sel)
            REG_DATA:   char_wr = print_wstrb[0];
            REG_STATUS: ovf_clr = print_wdata[OVF_CLR_BIT];
            default:    ;
          endcase
        end else begin
          case (sel)
            REG_STATUS: rdata_d = status_word(overflow, buf_empty);
            REG_COUNT:  rdata_d = count_q;
            default:    rdata_d = '0;
          endcase
        end
      end
    end
    if (char_wr) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      count_q <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end

  print_line_buffer #(
    .BUF_DEPTH(BUF_DEPTH),
    .ECHO     (ECHO)
  ) u_line_buffer (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (char_wr),
    .wr_char  (print_wdata[7:0]),
    .ovf_clr  (ovf_clr),
    .buf_empty(buf_empty),
    .overflow (overflow)
  );

  assign print_ready = ready_q;
  assign print_rdata = rdata_q;

endmodule

// File: tb/tb_print_console.sv
// Self-checking bench for print_console: directed cases plus random traffic
// compared against a register-level model of the console.
module tb_print_console;

  localparam int DEPTH = 128;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        print_valid = 1'b0;
  logic        print_instr = 1'b0;
  logic [31:0] print_addr = '0;
  logic [31:0] print_wdata = '0;
  logic [3:0]  print_wstrb = '0;
  logic [31:0] print_rdata;
  logic        print_ready;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_level;
  logic [31:0] m_count;
  bit          m_ovf;

  print_console #(.BUF_DEPTH(DEPTH), .ECHO(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .print_valid(print_valid),
    .print_instr(print_instr),
    .print_addr (print_addr),
    .print_wdata(print_wdata),
    .print_wstrb(print_wstrb),
    .print_rdata(print_rdata),
    .print_ready(print_ready)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_level = 0;
    m_count = 0;
    m_ovf   = 0;
  endfunction

  // Returns the expected read data and applies the request's side effects.
  function automatic logic [31:0] model_req(input logic [31:0] addr, input logic [31:0] wdata,
                                            input logic [3:0] wstrb, input logic instr);
    int sel;
    sel = int'(addr[3:2]);
    if (instr) return 32'h0;
    if (wstrb == 4'h0) begin
      if (sel == 1) return {29'b0, m_ovf, (m_level == 0), 1'b1};
      if (sel == 2) return m_count;
      return 32'h0;
    end
    if (sel == 0 && wstrb[0]) begin
      m_count = m_count + 1;
      m_level = m_level + 1;
      if (m_level == DEPTH) begin
        m_ovf   = 1;
        m_level = 0;
      end else if (wdata[7:0] == 8'h0A) begin
        m_level = 0;
      end
    end else if (sel == 1 && wdata[2]) begin
      m_ovf = 0;
    end
    return 32'h0;
  endfunction

  task automatic issue(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic instr);
    logic [31:0] exp;
    print_valid = 1'b1;
    print_addr  = addr;
    print_wdata = wdata;
    print_wstrb = wstrb;
    print_instr = instr;
    exp = model_req(addr, wdata, wstrb, instr);
    @(posedge clock); #1;
    check_eq({tag, "/ready"}, {31'b0, print_ready}, 32'h1);
    check_eq({tag, "/rdata"}, print_rdata, exp);
  endtask

  task automatic idle(input int n);
    print_valid = 1'b0;
    print_instr = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
      check_eq("idle/ready", {31'b0, print_ready}, 32'h0);
      check_eq("idle/rdata", print_rdata, 32'h0);
    end
  endtask

  task automatic wr_char(input string tag, input logic [7:0] ch);
    issue(tag, 32'h0, {24'h0, ch}, 4'b0001, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [1:0] sel);
    issue(tag, {28'h0, sel, 2'b00}, 32'h0, 4'h0, 1'b0);
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 8'($urandom_range(97, 122));
    if (r < 85) return 8'h0A;
    if (r < 90) return 8'h00;
    return 8'h20;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset held with valid toggling: no response may appear.
    for (int i = 0; i < 10; i++) begin
      print_valid = (i % 2 == 0);
      print_addr  = 32'h4;
      print_wstrb = 4'h0;
      @(posedge clock); #1;
      check_eq("rst/ready", {31'b0, print_ready}, 32'h0);
      check_eq("rst/rdata", print_rdata, 32'h0);
    end
    print_valid = 1'b0;
    reset = 1'b1;
    idle(1);
    rd("rst_status", 2'd1);
    idle(1);

    wr_char("wr_H", 8'h48);
    idle(1);
    rd("count1", 2'd2);
    rd("status1", 2'd1);
    idle(1);

    wr_char("hi_H", 8'h48);
    wr_char("hi_i", 8'h69);
    wr_char("hi_nl", 8'h0A);
    idle(1);
    rd("hi_status", 2'd1);
    rd("hi_count", 2'd2);
    idle(1);

    for (int i = 0; i < DEPTH; i++) begin
      wr_char("ovf_char", 8'($urandom_range(97, 122)));
    end
    rd("ovf_status", 2'd1);
    issue("ovf_clr", 32'h4, 32'h4, 4'hF, 1'b0);
    rd("ovf_clr_status", 2'd1);
    wr_char("ovf_nl", 8'h0A);
    idle(1);

    issue("instr_wr", 32'h0, 32'h41, 4'b0001, 1'b1);
    rd("instr_count", 2'd2);
    issue("strb_hi", 32'h0, 32'h41, 4'b0010, 1'b0);
    rd("strb_count", 2'd2);
    issue("rsvd_rd", 32'hC, 32'h0, 4'h0, 1'b0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] up;
      logic [31:0] addr;
      logic [3:0]  strb;
      int          s;
      int          r;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      s = $urandom_range(0, 6);
      if (s > 3) s = 0;
      up   = $urandom;
      addr = {up[31:4], 2'(s), up[1:0]};
      r = $urandom_range(0, 9);
      if (r < 4)      strb = 4'h0;
      else if (r < 9) strb = 4'b0001 | 4'($urandom_range(0, 15));
      else            strb = 4'($urandom_range(0, 15));
      up = $urandom;
      issue("rand", addr, {up[31:8], rand_char()}, strb, ($urandom_range(0, 7) == 0));
    end
    wr_char("rand_nl", 8'h0A);
    idle(1);
    rd("rand_count", 2'd2);
    rd("rand_status", 2'd1);

    // Reset arriving while a partial line is buffered and a request is pending.
    wr_char("mid_a", 8'h61);
    wr_char("mid_b", 8'h62);
    print_valid = 1'b1;
    print_addr  = 32'h0;
    print_wdata = 32'h63;
    print_wstrb = 4'b0001;
    #3;
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("mid_rst/ready", {31'b0, print_ready}, 32'h0);
    check_eq("mid_rst/rdata", print_rdata, 32'h0);
    print_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    idle(1);
    rd("mid_count", 2'd2);
    rd("mid_status", 2'd1);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
